// File: rtl/sd_rw_arbiter.sv
// Arbitrates one SPI SD card between a write and a read requester and steers sd_cs/sd_mosi.
// Define SD_ARB_WR_PRIO_EN for fixed write priority; round robin otherwise.
module sd_rw_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int GAP_CYC   = 8,
    parameter int BUSY_WAIT = 16,
    parameter int TIMEOUT_W = 24
) (
    input  logic              clk_25m,
    input  logic              rst,
    input  logic              sd_init_done,
    input  logic              init_sd_cs,
    input  logic              init_sd_mosi,
    input  logic              wr_sd_cs,
    input  logic              wr_sd_mosi,
    input  logic              rd_sd_cs,
    input  logic              rd_sd_mosi,
    output logic              sd_cs,
    output logic              sd_mosi,
    input  logic              u_wr_req,
    input  logic [ADDR_W-1:0] u_wr_addr,
    output logic              u_wr_ack,
    input  logic              u_rd_req,
    input  logic [ADDR_W-1:0] u_rd_addr,
    output logic              u_rd_ack,
    output logic              wr_start_en,
    output logic [ADDR_W-1:0] wr_sec_addr,
    input  logic              wr_busy,
    output logic              rd_start_en,
    output logic [ADDR_W-1:0] rd_sec_addr,
    input  logic              rd_busy,
    output logic              arb_busy,
    output logic [1:0]        owner,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARB     = 3'd1,
        START   = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        GAP     = 3'd5
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_WR   = 2'b01;
    localparam logic [1:0] OWN_RD   = 2'b10;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_owner;
    logic [1:0]            w_owner_nxt;
    logic [TIMEOUT_W-1:0]  r_cnt;
    logic                  r_last_rd;
    logic                  r_timeout;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [ADDR_W-1:0]     r_rd_addr;
    logic                  w_pick_wr;
    logic                  w_pick_rd;
    logic                  w_grant_wr;
    logic                  w_grant_rd;
    logic                  w_to;
    logic                  w_busy_sel;

`ifdef SD_ARB_WR_PRIO_EN
    assign w_pick_wr = u_wr_req;
`else
    // On contention the side that did not win last time goes next.
    assign w_pick_wr = u_wr_req && (!u_rd_req || r_last_rd);
`endif
    assign w_pick_rd  = u_rd_req && !w_pick_wr;
    assign w_busy_sel = (r_owner == OWN_WR) ? wr_busy : rd_busy;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_grant_wr  = 1'b0;
        w_grant_rd  = 1'b0;
        w_to        = 1'b0;
        if (!sd_init_done) begin
            w_state_nxt = IDLE;
            w_owner_nxt = OWN_NONE;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = ARB;
                ARB: begin
                    if (w_pick_wr) begin
                        w_grant_wr  = 1'b1;
                        w_owner_nxt = OWN_WR;
                        w_state_nxt = START;
                    end else if (w_pick_rd) begin
                        w_grant_rd  = 1'b1;
                        w_owner_nxt = OWN_RD;
                        w_state_nxt = START;
                    end
                end
                START: w_state_nxt = WAIT_HI;
                WAIT_HI: begin
                    if (w_busy_sel) begin
                        w_state_nxt = WAIT_LO;
                    end else if (r_cnt == TIMEOUT_W'(BUSY_WAIT - 1)) begin
                        w_to        = 1'b1;
                        w_owner_nxt = OWN_NONE;
                        w_state_nxt = GAP;
                    end
                end
                WAIT_LO: begin
                    if (!w_busy_sel) begin
                        w_owner_nxt = OWN_NONE;
                        w_state_nxt = GAP;
                    end else if (&r_cnt) begin
                        w_to        = 1'b1;
                        w_owner_nxt = OWN_NONE;
                        w_state_nxt = GAP;
                    end
                end
                GAP: begin
                    if (r_cnt == TIMEOUT_W'(GAP_CYC - 1)) begin
                        w_state_nxt = ARB;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_owner_nxt = OWN_NONE;
                end
            endcase
        end
    end

    // r_cnt restarts on every state change, so it serves as watchdog and gap timer.
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= OWN_NONE;
            r_cnt     <= '0;
            r_last_rd <= 1'b1;
            r_timeout <= 1'b0;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + TIMEOUT_W'(1);
            if (w_to) begin
                r_timeout <= 1'b1;
            end
            if (w_grant_wr) begin
                r_wr_addr <= u_wr_addr;
                r_last_rd <= 1'b0;
            end
            if (w_grant_rd) begin
                r_rd_addr <= u_rd_addr;
                r_last_rd <= 1'b1;
            end
        end
    end

    assign wr_start_en = (r_state == START) && (r_owner == OWN_WR);
    assign rd_start_en = (r_state == START) && (r_owner == OWN_RD);
    assign u_wr_ack    = wr_start_en;
    assign u_rd_ack    = rd_start_en;
    assign wr_sec_addr = r_wr_addr;
    assign rd_sec_addr = r_rd_addr;
    assign arb_busy    = (r_state != IDLE) && (r_state != ARB);
    assign owner       = r_owner;
    assign timeout_err = r_timeout;

    always_comb begin
        sd_cs   = 1'b1;
        sd_mosi = 1'b1;
        if (!sd_init_done) begin
            sd_cs   = init_sd_cs;
            sd_mosi = init_sd_mosi;
        end else if (r_owner == OWN_WR) begin
            sd_cs   = wr_sd_cs;
            sd_mosi = wr_sd_mosi;
        end else if (r_owner == OWN_RD) begin
            sd_cs   = rd_sd_cs;
            sd_mosi = rd_sd_mosi;
        end
    end

endmodule

// File: tb/tb_sd_rw_arbiter.sv
// Scoreboard bench for sd_rw_arbiter: expected grant kinds/addresses are queued when requests are raised.
module tb_sd_rw_arbiter;
    localparam int ADDR_W    = 32;
    localparam int GAP_CYC   = 8;
    localparam int BUSY_WAIT = 16;
    localparam int TIMEOUT_W = 24;

    logic              clk_25m = 1'b0;
    logic              rst = 1'b1;
    logic              sd_init_done = 1'b0;
    logic              init_sd_cs = 1'b1, init_sd_mosi = 1'b1;
    logic              wr_sd_cs = 1'b1, wr_sd_mosi = 1'b1;
    logic              rd_sd_cs = 1'b1, rd_sd_mosi = 1'b1;
    logic              sd_cs, sd_mosi;
    logic              u_wr_req = 1'b0, u_rd_req = 1'b0;
    logic [ADDR_W-1:0] u_wr_addr = '0, u_rd_addr = '0;
    logic              u_wr_ack, u_rd_ack;
    logic              wr_start_en, rd_start_en;
    logic [ADDR_W-1:0] wr_sec_addr, rd_sec_addr;
    logic              wr_busy = 1'b0, rd_busy = 1'b0;
    logic              arb_busy;
    logic [1:0]        owner;
    logic              timeout_err;

    int n_vec = 0;
    int n_err = 0;
    int q_kind[$];
    logic [ADDR_W-1:0] q_wr_addr[$];
    logic [ADDR_W-1:0] q_rd_addr[$];
    int wr_left = 0, rd_left = 0;
    int wr_len = 4, rd_len = 4;
    bit rd_never = 1'b0;
    int ack_cnt = 0, start_cnt = 0, zero_run = 0;
    bit have_prev = 1'b0;

    sd_rw_arbiter #(
        .ADDR_W(ADDR_W), .GAP_CYC(GAP_CYC), .BUSY_WAIT(BUSY_WAIT), .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clk_25m(clk_25m), .rst(rst), .sd_init_done(sd_init_done),
        .init_sd_cs(init_sd_cs), .init_sd_mosi(init_sd_mosi),
        .wr_sd_cs(wr_sd_cs), .wr_sd_mosi(wr_sd_mosi),
        .rd_sd_cs(rd_sd_cs), .rd_sd_mosi(rd_sd_mosi),
        .sd_cs(sd_cs), .sd_mosi(sd_mosi),
        .u_wr_req(u_wr_req), .u_wr_addr(u_wr_addr), .u_wr_ack(u_wr_ack),
        .u_rd_req(u_rd_req), .u_rd_addr(u_rd_addr), .u_rd_ack(u_rd_ack),
        .wr_start_en(wr_start_en), .wr_sec_addr(wr_sec_addr), .wr_busy(wr_busy),
        .rd_start_en(rd_start_en), .rd_sec_addr(rd_sec_addr), .rd_busy(rd_busy),
        .arb_busy(arb_busy), .owner(owner), .timeout_err(timeout_err)
    );

    initial forever #20 clk_25m = ~clk_25m;

    // Engine pins toggle randomly so the mux selection is observable.
    initial forever begin
        @(posedge clk_25m);
        #1;
        init_sd_cs   = 1'($urandom);
        init_sd_mosi = 1'($urandom);
        wr_sd_cs     = 1'($urandom);
        wr_sd_mosi   = 1'($urandom);
        rd_sd_cs     = 1'($urandom);
        rd_sd_mosi   = 1'($urandom);
    end

    initial forever begin
        @(negedge clk_25m);
        if (wr_start_en) begin
            wr_busy = 1'b1;
            repeat (wr_len) @(negedge clk_25m);
            wr_busy = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk_25m);
        if (rd_start_en && !rd_never) begin
            rd_busy = 1'b1;
            repeat (rd_len) @(negedge clk_25m);
            rd_busy = 1'b0;
        end
    end

    initial begin
        #4ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: sample at the falling edge, score acks, then act as both requesters.
    task automatic step();
        @(negedge clk_25m);
        chk("start_exclusive", wr_start_en & rd_start_en, 0);
        chk("wr_ack_eq_start", u_wr_ack, wr_start_en);
        chk("rd_ack_eq_start", u_rd_ack, rd_start_en);
        if (u_wr_ack) ack_cnt++;
        if (u_rd_ack) ack_cnt++;
        if (wr_start_en) start_cnt++;
        if (rd_start_en) start_cnt++;
        if (u_wr_ack || u_rd_ack) begin
            if (have_prev) chk("gap_owner_none_len_ok", zero_run >= GAP_CYC + 1, 1);
            have_prev = 1'b1;
            chk("ack_expected", q_kind.size() > 0, 1);
            if (q_kind.size() > 0) chk("grant_kind", u_rd_ack ? 2 : 1, q_kind.pop_front());
            if (u_wr_ack) begin
                chk("wr_addr_queued", q_wr_addr.size() > 0, 1);
                if (q_wr_addr.size() > 0) chk("wr_sec_addr", wr_sec_addr, q_wr_addr.pop_front());
                wr_left--;
                if (wr_left > 0) begin
                    u_wr_addr = u_wr_addr + 1;
                    q_wr_addr.push_back(u_wr_addr);
                end else begin
                    u_wr_req = 1'b0;
                end
            end
            if (u_rd_ack) begin
                chk("rd_addr_queued", q_rd_addr.size() > 0, 1);
                if (q_rd_addr.size() > 0) chk("rd_sec_addr", rd_sec_addr, q_rd_addr.pop_front());
                rd_left--;
                if (rd_left > 0) begin
                    u_rd_addr = u_rd_addr + 1;
                    q_rd_addr.push_back(u_rd_addr);
                end else begin
                    u_rd_req = 1'b0;
                end
            end
        end
        if (owner == 2'b00) zero_run++;
        else zero_run = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) step();
    endtask

    task automatic wait_ack(input int limit, output int lat);
        lat = 0;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (u_wr_ack || u_rd_ack) begin
                lat = i;
                break;
            end
        end
        chk("ack_within_bound", lat > 0, 1);
    endtask

    task automatic wait_drain(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (q_kind.size() == 0 && !arb_busy && !u_wr_req && !u_rd_req) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_within_bound", ok, 1);
    endtask

    initial begin
        int lat;
        int bad;
        int s0;

        // Reset with card uninitialised and a write already requested
        wr_left  = 1;
        wr_len   = 600;
        u_wr_addr = 32'h0000_1234;
        q_wr_addr.push_back(u_wr_addr);
        u_wr_req = 1'b1;
        cyc(3);
        rst = 1'b0;
        step();
        chk("rst_owner", owner, 2'b00);
        chk("rst_arb_busy", arb_busy, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_wr_sec_addr", wr_sec_addr, 0);
        chk("rst_rd_sec_addr", rd_sec_addr, 0);
        chk("rst_wr_ack", u_wr_ack, 0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (sd_cs !== init_sd_cs || sd_mosi !== init_sd_mosi) bad++;
        end
        chk("init_mux_follow", bad, 0);
        chk("no_ack_before_init", ack_cnt, 0);

        // Init completes: ack two cycles later (IDLE->ARB, ARB->START)
        q_kind.push_back(1);
        sd_init_done = 1'b1;
        wait_ack(20, lat);
        chk("first_ack_latency", lat, 2);

        // Long write: owner held, then GAP_CYC idle cycles, then ARB
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (owner !== 2'b01 || sd_cs !== wr_sd_cs || sd_mosi !== wr_sd_mosi) bad++;
        end
        chk("wr_owner_hold", bad, 0);
        bad = 0;
        for (int i = 0; i < GAP_CYC; i++) begin
            step();
            if (owner !== 2'b00 || sd_cs !== 1'b1 || sd_mosi !== 1'b1 || arb_busy !== 1'b1) bad++;
        end
        chk("gap_lines_idle", bad, 0);
        step();
        chk("back_to_arb", arb_busy, 0);

        // Contended requests after a fresh reset
        wr_len = 3;
        rd_len = 3;
        rst = 1'b1;
        have_prev = 1'b0;
        wr_left = 4;
        rd_left = 2;
        u_wr_addr = 32'hA000_0000;
        q_wr_addr.push_back(u_wr_addr);
        u_rd_addr = 32'hB000_0000;
        q_rd_addr.push_back(u_rd_addr);
        u_wr_req = 1'b1;
        u_rd_req = 1'b1;
`ifdef SD_ARB_WR_PRIO_EN
        q_kind = '{1, 1, 1, 1, 2, 2};
`else
        q_kind = '{1, 2, 1, 2, 1, 1};
`endif
        cyc(2);
        rst = 1'b0;
        wait_drain(3000);
        chk("rr_timeout_clear", timeout_err, 0);

        // Read whose busy never rises: watchdog fires after BUSY_WAIT cycles
        rd_never = 1'b1;
        rd_left = 1;
        u_rd_addr = 32'h0BAD_0001;
        q_rd_addr.push_back(u_rd_addr);
        q_kind.push_back(2);
        u_rd_req = 1'b1;
        wait_ack(50, lat);
        cyc(BUSY_WAIT);
        chk("wd_not_yet", timeout_err, 0);
        chk("wd_owner_rd", owner, 2'b10);
        step();
        chk("wd_fired", timeout_err, 1);
        chk("wd_owner_none", owner, 2'b00);
        chk("wd_sd_cs_high", sd_cs, 1);
        wait_drain(100);
        rd_never = 1'b0;
        wr_left = 1;
        u_wr_addr = 32'h0000_0055;
        q_wr_addr.push_back(u_wr_addr);
        q_kind.push_back(1);
        u_wr_req = 1'b1;
        wait_ack(50, lat);
        wait_drain(100);
        chk("wd_sticky", timeout_err, 1);

        // sd_init_done drops in the middle of a read's busy phase
        rd_len = 30;
        rd_left = 1;
        u_rd_addr = 32'h0000_0077;
        q_rd_addr.push_back(u_rd_addr);
        q_kind.push_back(2);
        u_rd_req = 1'b1;
        wait_ack(50, lat);
        cyc(8);
        chk("drop_pre_owner", owner, 2'b10);
        sd_init_done = 1'b0;
        rd_left = 1;
        u_rd_addr = 32'h0000_0088;
        q_rd_addr.push_back(u_rd_addr);
        u_rd_req = 1'b1;
        step();
        chk("drop_owner_none", owner, 2'b00);
        chk("drop_arb_idle", arb_busy, 0);
        chk("drop_cs_init", sd_cs, init_sd_cs);
        chk("drop_mosi_init", sd_mosi, init_sd_mosi);
        s0 = start_cnt;
        cyc(40);
        chk("no_start_while_uninit", start_cnt - s0, 0);
        q_kind.push_back(2);
        sd_init_done = 1'b1;
        wait_ack(20, lat);
        chk("regrant_latency", lat, 2);
        wait_drain(200);

        chk("ack_count_eq_start_count", ack_cnt, start_cnt);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
